// File: rtl/fft_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : fft_frame_sequencer_if
// Brief   : Handshake bundle between the frame sequencer and the FFT chain.
// Revision: 1.0 - initial release
// ============================================================================
interface fft_frame_sequencer_if #(
    parameter int SIZE = 5
);
    logic            run_i;
    logic            buf_full_i;
    logic            load_en_o;
    logic [SIZE:0]   load_addr_o;
    logic            fft_start_o;
    logic            fft_done_i;
    logic [SIZE-1:0] out_idx_o;
    logic            tx_en_o;
    logic            tx_done_i;
    logic            busy_o;
    logic [15:0]     frame_cnt_o;
    logic            err_o;

    // Sequencer side
    modport master (
        input  run_i, buf_full_i, fft_done_i, tx_done_i,
        output load_en_o, load_addr_o, fft_start_o, out_idx_o,
               tx_en_o, busy_o, frame_cnt_o, err_o
    );

    // FFT chain / environment side
    modport slave (
        output run_i, buf_full_i, fft_done_i, tx_done_i,
        input  load_en_o, load_addr_o, fft_start_o, out_idx_o,
               tx_en_o, busy_o, frame_cnt_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fft_frame_sequencer
// Brief   : Loads a frame into the FFT core in bit-reversed order, starts it,
//           then drains the results through the UART handshake.
//           Optional watchdog/ERR state: define FFT_SEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fft_frame_sequencer #(
    parameter int N       = 32,
    parameter int SIZE    = 5,
    parameter int TIMEOUT = 4096
) (
    input  wire logic             clk,
    input  wire logic             rst_n,   // active-high asynchronous reset
    fft_frame_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_COMPUTE = 3'd3,
        S_TX_REQ  = 3'd4,
        S_TX_WAIT = 3'd5
`ifdef FFT_SEQ_TIMEOUT_EN
        ,
        S_ERR     = 3'd6
`endif
    } state_t;

    localparam logic [SIZE-1:0] c_LAST = SIZE'(N - 1);

    state_t          r_state;
    logic [SIZE-1:0] r_load_idx;
    logic [SIZE-1:0] r_out_idx;
    logic            r_load_en;
    logic [SIZE:0]   r_load_addr;
    logic            r_fft_start;
    logic            r_tx_en;
    logic            r_busy;
    logic [15:0]     r_frame_cnt;
    logic [SIZE-1:0] w_load_next;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_err;
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] v);
        logic [SIZE-1:0] r;
        for (int b = 0; b < SIZE; b++) begin
            r[b] = v[SIZE-1-b];
        end
        return r;
    endfunction

    assign w_load_next = r_load_idx + SIZE'(1);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= S_IDLE;
            r_load_idx  <= '0;
            r_out_idx   <= '0;
            r_load_en   <= 1'b0;
            r_load_addr <= '0;
            r_fft_start <= 1'b0;
            r_tx_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
            r_wd_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            // One-cycle strobes fall back to 0 unless a transition raises them.
            r_fft_start <= 1'b0;
            r_tx_en     <= 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
            r_wd_cnt    <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.run_i && bus.buf_full_i) begin
                        r_state     <= S_LOAD;
                        r_load_idx  <= '0;
                        r_load_en   <= 1'b1;
                        r_load_addr <= {1'b0, bitrev('0)};
                        r_busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (r_load_idx == c_LAST) begin
                        r_load_en   <= 1'b0;
                        r_fft_start <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_load_idx  <= w_load_next;
                        r_load_addr <= {1'b0, bitrev(w_load_next)};
                    end
                end
                S_START: begin
                    r_state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (bus.fft_done_i) begin
                        r_tx_en   <= 1'b1;
                        r_out_idx <= '0;
                        r_state   <= S_TX_REQ;
                    end
`ifdef FFT_SEQ_TIMEOUT_EN
                    else if (r_wd_cnt == c_WD_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
                    end
`endif
                end
                S_TX_REQ: begin
                    r_state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (bus.tx_done_i) begin
                        if (r_out_idx == c_LAST) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_out_idx <= r_out_idx + SIZE'(1);
                            r_tx_en   <= 1'b1;
                            r_state   <= S_TX_REQ;
                        end
                    end
`ifdef FFT_SEQ_TIMEOUT_EN
                    else if (r_wd_cnt == c_WD_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
                    end
`endif
                end
`ifdef FFT_SEQ_TIMEOUT_EN
                S_ERR: begin
                    if (!bus.run_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_en_o   = r_load_en;
    assign bus.load_addr_o = r_load_addr;
    assign bus.fft_start_o = r_fft_start;
    assign bus.out_idx_o   = r_out_idx;
    assign bus.tx_en_o     = r_tx_en;
    assign bus.busy_o      = r_busy;
    assign bus.frame_cnt_o = r_frame_cnt;
`ifdef FFT_SEQ_TIMEOUT_EN
    assign bus.err_o       = r_err;
`else
    assign bus.err_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_frame_sequencer
// Brief   : Randomized self-checking bench for fft_frame_sequencer against a
//           frame-level reference model (bit-reverse order, result order, count).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_frame_sequencer;

    localparam int N       = 32;
    localparam int SIZE    = 5;
    localparam int TIMEOUT = 4096;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   exp_frames;

    fft_frame_sequencer_if #(.SIZE(SIZE)) bus ();

    fft_frame_sequencer #(
        .N       (N),
        .SIZE    (SIZE),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish within bound");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv)
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, expv, expv);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit reversal by repeated division: least significant input bit becomes MSB.
    function automatic int ref_bitrev(input int i);
        int r = 0;
        int v = i;
        for (int b = 0; b < SIZE; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic run_frame(input int fft_lat, input int uart_dly, input int stop_k,
                             input int reset_k, input bit spur, input bit keep_full,
                             input bit wd);
        int waited;
        int d;
        bus.run_i      = 1'b1;
        bus.buf_full_i = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!bus.load_en_o && waited < 4);
        check("start_lat", waited, 1);
        if (!bus.load_en_o) return;

        bus.buf_full_i = keep_full;
        for (int i = 0; i < N; i++) begin
            check("load_en", bus.load_en_o, 1);
            check("load_addr", bus.load_addr_o, ref_bitrev(i));
            check("load_strobes", {bus.fft_start_o, bus.tx_en_o, bus.busy_o}, 3'b001);
            bus.fft_done_i = spur && (i == 3);
            tick();
        end
        bus.fft_done_i = 1'b0;
        check("start_pulse", {bus.load_en_o, bus.fft_start_o}, 2'b01);
        tick();
        check("start_once", {bus.fft_start_o, bus.busy_o}, 2'b01);

        if (wd) begin
            for (int j = 0; j < TIMEOUT; j++) begin
                if (j == 0 || j == TIMEOUT - 1) check("wd_pre_err", bus.err_o, 0);
                tick();
            end
`ifdef FFT_SEQ_TIMEOUT_EN
            check("wd_err", bus.err_o, 1);
            check("wd_err_strobes", {bus.busy_o, bus.tx_en_o, bus.load_en_o, bus.fft_start_o}, 4'b1000);
            bus.run_i = 1'b0;
            tick();
            check("err_to_idle", bus.busy_o, 0);
            check("err_sticky", bus.err_o, 1);
            return;
`else
            check("wd_no_err", bus.err_o, 0);
            check("wd_still_compute", {bus.busy_o, bus.tx_en_o}, 2'b10);
            bus.fft_done_i = 1'b1;
            tick();
`endif
        end else begin
            for (int j = 0; j < fft_lat; j++) begin
                check("compute_quiet", {bus.tx_en_o, bus.load_en_o, bus.fft_start_o}, 3'b000);
                bus.tx_done_i  = spur && (j == 1);
                bus.fft_done_i = (j == fft_lat - 1);
                tick();
            end
        end
        bus.fft_done_i = 1'b0;
        bus.tx_done_i  = 1'b0;

        for (int k = 0; k < N; k++) begin
            check("tx_en", bus.tx_en_o, 1);
            check("out_idx", bus.out_idx_o, k);
            if (k == reset_k) begin
                #2 rst_n = 1'b1;
                #1;
                check("rst_outputs",
                      {bus.load_en_o, bus.load_addr_o, bus.fft_start_o, bus.out_idx_o,
                       bus.tx_en_o, bus.busy_o, bus.err_o}, 0);
                check("rst_frame_cnt", bus.frame_cnt_o, 0);
                tick();
                rst_n = 1'b0;
                exp_frames = 0;
                return;
            end
            if (k == stop_k) bus.run_i = 1'b0;
            tick();
            check("tx_wait_en", bus.tx_en_o, 0);
            check("tx_wait_idx", bus.out_idx_o, k);
            d = (uart_dly > 0) ? uart_dly : int'($urandom_range(1, 12));
            for (int w = 1; w < d; w++) tick();
            bus.tx_done_i = 1'b1;
            tick();
            bus.tx_done_i = 1'b0;
        end
        exp_frames = (exp_frames + 1) % 65536;
        check("frame_cnt", bus.frame_cnt_o, exp_frames);
        check("end_idle", {bus.busy_o, bus.tx_en_o, bus.load_en_o}, 3'b000);
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        exp_frames     = 0;
        rst_n          = 1'b1;
        bus.run_i      = 1'b0;
        bus.buf_full_i = 1'b0;
        bus.fft_done_i = 1'b0;
        bus.tx_done_i  = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              {bus.load_en_o, bus.load_addr_o, bus.fft_start_o, bus.out_idx_o,
               bus.tx_en_o, bus.busy_o, bus.err_o}, 0);
        check("reset_frame_cnt", bus.frame_cnt_o, 0);
        rst_n = 1'b0;
        tick();

        // Nominal frame with a 10-cycle UART
        run_frame($urandom_range(1, 20), 10, -1, -1, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with the buffer kept full
        run_frame($urandom_range(1, 20), 0, -1, -1, 1'b0, 1'b1, 1'b0);
        run_frame($urandom_range(1, 20), 0, -1, -1, 1'b0, 1'b0, 1'b0);

        // Spurious handshakes outside their states
        run_frame($urandom_range(3, 25), 0, -1, -1, 1'b1, 1'b0, 1'b0);

        // Stop request at k = 5, then stay parked despite a full buffer
        run_frame($urandom_range(1, 20), 0, 5, -1, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 8; p++) begin
            check("park_idle", {bus.busy_o, bus.load_en_o}, 2'b00);
            tick();
        end

        // Reset at k = 12, then a clean frame
        run_frame($urandom_range(1, 20), 0, -1, 12, 1'b0, 1'b0, 1'b0);
        run_frame($urandom_range(1, 20), 0, -1, -1, 1'b0, 1'b0, 1'b0);

        // Random frames
        for (int f = 0; f < 3; f++) begin
            run_frame($urandom_range(3, 30), 0, int'($urandom_range(0, 40)), -1,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Withheld fft_done: watchdog behaviour
        run_frame(1, 0, -1, -1, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
